// File: rtl/arm_pkg.sv
// Shared definitions for the instruction-fetch slice.
// Holds the word width, the bubble instruction encoding, the fetch FSM state type
// and small PC arithmetic helpers used by the fetch unit.
package arm_pkg;

  localparam int unsigned WORD_LENGTH = 32;
  localparam logic [WORD_LENGTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } fetch_state_e;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [WORD_LENGTH-1:0] pc_next(input logic [WORD_LENGTH-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [WORD_LENGTH-1:0] word_align(input logic [WORD_LENGTH-1:0] addr);
    return {addr[WORD_LENGTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   load_i           capture pc_i/instr_i as a valid instruction
//   flush_i          load a bubble (wins over load_i)
//   pc_i, instr_i    incoming fetch result
//   pc_o, instr_o    registered values presented to decode
//   valid_o          instr_o holds a real instruction
// With neither load_i nor flush_i the register holds its contents.
module if_id_register
  import arm_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic                   flush_i,
  input  logic [WORD_LENGTH-1:0] pc_i,
  input  logic [WORD_LENGTH-1:0] instr_i,
  output logic [WORD_LENGTH-1:0] pc_o,
  output logic [WORD_LENGTH-1:0] instr_o,
  output logic                   valid_o
);

  logic [WORD_LENGTH-1:0] pc_q, pc_d;
  logic [WORD_LENGTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (load_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: single-outstanding request/grant/rvalid fetch engine
// feeding the IF/ID register.
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   freeze                         decode stall; holds PC and IF/ID
//   branch_taken, branch_addr      one-cycle redirect from EX (wins over freeze)
//   imem_req/addr/gnt/rvalid/rdata instruction-memory port
//   pc_out, instruction_out        IF/ID contents (pc_out is fetch PC + 4)
//   valid_out                      IF/ID holds a real instruction
//   misalign_err                   sticky misaligned-branch flag
// Build option: define IF_MISALIGN_CHECK_EN to flag misaligned branch targets;
// otherwise the target's low two bits are dropped and misalign_err is tied low.
module if_fetch_unit
  import arm_pkg::*;
#(
  parameter logic [WORD_LENGTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [WORD_LENGTH-1:0] branch_addr,
  output logic                   imem_req,
  output logic [WORD_LENGTH-1:0] imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [WORD_LENGTH-1:0] imem_rdata,
  output logic [WORD_LENGTH-1:0] pc_out,
  output logic [WORD_LENGTH-1:0] instruction_out,
  output logic                   valid_out,
  output logic                   misalign_err
);

  fetch_state_e           state_q, state_d;
  logic [WORD_LENGTH-1:0] pc_q, pc_d;
  logic [WORD_LENGTH-1:0] hold_pc_q, hold_pc_d;
  logic [WORD_LENGTH-1:0] hold_instr_q, hold_instr_d;
  logic                   kill_q, kill_d;
  logic [WORD_LENGTH-1:0] br_target;
  logic                   ifid_load, ifid_flush;
  logic [WORD_LENGTH-1:0] ifid_pc, ifid_instr;

  assign br_target = word_align(branch_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      kill_q       <= 1'b0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      kill_q       <= kill_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    kill_d       = kill_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (branch_taken) pc_d = br_target;
      end
      StReq: begin
        // A grant in a redirect cycle still accepts the old-PC request, so its data must be dropped.
        if (branch_taken) pc_d = br_target;
        if (imem_gnt) begin
          state_d = StWait;
          kill_d  = branch_taken;
        end
      end
      StWait: begin
        if (branch_taken) begin
          pc_d = br_target;
          if (imem_rvalid) begin
            state_d = StReq;
            kill_d  = 1'b0;
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          state_d = StReq;
          if (kill_q) begin
            kill_d = 1'b0;
          end else if (freeze) begin
            state_d      = StHold;
            hold_pc_d    = pc_next(pc_q);
            hold_instr_d = imem_rdata;
          end else begin
            pc_d = pc_next(pc_q);
          end
        end
      end
      StHold: begin
        if (branch_taken) begin
          pc_d    = br_target;
          state_d = StReq;
        end else if (!freeze) begin
          pc_d    = pc_next(pc_q);
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = pc_q;
    ifid_load  = 1'b0;
    ifid_pc    = pc_next(pc_q);
    ifid_instr = imem_rdata;
    unique case (state_q)
      // Redirect drops the request unless the memory grants in the same cycle.
      StReq:  imem_req = !branch_taken || imem_gnt;
      StWait: ifid_load = imem_rvalid && !kill_q && !freeze && !branch_taken;
      StHold: begin
        ifid_load  = !freeze && !branch_taken;
        ifid_pc    = hold_pc_q;
        ifid_instr = hold_instr_q;
      end
      default: ;
    endcase
    // Any unstalled cycle without a new instruction shifts in a bubble.
    ifid_flush = branch_taken || (!freeze && !ifid_load);
  end

  if_id_register u_if_id_register (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .pc_i    (ifid_pc),
    .instr_i (ifid_instr),
    .pc_o    (pc_out),
    .instr_o (instruction_out),
    .valid_o (valid_out)
  );

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misalign_d = misalign_q || (branch_taken && (branch_addr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_err = misalign_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^branch_addr[1:0];
  assign misalign_err    = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run against a
// transaction-level reference model of the fetch stream.
module tb_if_fetch_unit;

`ifdef IF_MISALIGN_CHECK_EN
  localparam logic MisEn = 1'b1;
`else
  localparam logic MisEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .misalign_err    (misalign_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  task automatic drive(input logic fz, input logic br, input logic [31:0] ba,
                       input logic g, input logic rv, input logic [31:0] rd);
    freeze       = fz;
    branch_taken = br;
    branch_addr  = ba;
    imem_gnt     = g;
    imem_rvalid  = rv;
    imem_rdata   = rd;
  endtask

  // One clock; branch and rvalid are single-cycle pulses.
  task automatic step();
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    imem_rvalid  = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    rst = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
    total++; if (instruction_out !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instruction_out); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req: got %b want 0", imem_req); end
  endtask

  task automatic test_basic();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL basic_req: got %b want 1", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL basic_addr: got %h want 0", imem_addr); end
    step();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL basic_wait_req: got %b want 0", imem_req); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE3A0_1005);
    step();
    total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL basic_pc_out: got %h want 4", pc_out); end
    total++; if (instruction_out !== 32'hE3A0_1005) begin bad++; $display("FAIL basic_instr: got %h want e3a01005", instruction_out); end
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", valid_out); end
    total++; if (imem_addr !== 32'h4) begin bad++; $display("FAIL basic_next_addr: got %h want 4", imem_addr); end
  endtask

  task automatic test_freeze();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hE081_2002);
    step();
    step();
    total++; if ({pc_out, instruction_out, valid_out} !== {32'h4, 32'hE3A0_1005, 1'b1}) begin
      bad++; $display("FAIL freeze_hold: got pc=%h ins=%h v=%b want pc=4 ins=e3a01005 v=1", pc_out, instruction_out, valid_out);
    end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL freeze_req: got %b want 0", imem_req); end
    freeze = 1'b0;
    step();
    total++; if ({pc_out, instruction_out, valid_out} !== {32'h8, 32'hE081_2002, 1'b1}) begin
      bad++; $display("FAIL freeze_release: got pc=%h ins=%h v=%b want pc=8 ins=e0812002 v=1", pc_out, instruction_out, valid_out);
    end
    total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL freeze_next_addr: got %h want 8", imem_addr); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL freeze_next_req: got %b want 1", imem_req); end
  endtask

  task automatic test_branch_wait();
    step();
    drive(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0);
    step();
    total++; if ({pc_out, instruction_out, valid_out} !== 65'h0) begin
      bad++; $display("FAIL brwait_flush: got pc=%h ins=%h v=%b want bubble", pc_out, instruction_out, valid_out);
    end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL brwait_req: got %b want 0", imem_req); end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    step();
    total++; if ({instruction_out, valid_out} !== 33'h0) begin
      bad++; $display("FAIL brwait_discard: got ins=%h v=%b want 0/0", instruction_out, valid_out);
    end
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin
      bad++; $display("FAIL brwait_addr: got req=%b addr=%h want 1/40", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_freeze();
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1111_2222);
    step();
    total++; if ({pc_out, valid_out} !== {32'h44, 1'b1}) begin
      bad++; $display("FAIL brfz_pre: got pc=%h v=%b want 44/1", pc_out, valid_out);
    end
    drive(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL brfz_req_drop: got %b want 0", imem_req); end
    step();
    freeze = 1'b0;
    #1;
    total++; if ({pc_out, instruction_out, valid_out} !== 65'h0) begin
      bad++; $display("FAIL brfz_flush: got pc=%h ins=%h v=%b want bubble", pc_out, instruction_out, valid_out);
    end
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h80}) begin
      bad++; $display("FAIL brfz_addr: got req=%b addr=%h want 1/80", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    step();
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); end
    imem_gnt = 1'b1;
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D);
    step();
    total++; if ({pc_out, instruction_out, valid_out} !== {32'h0, 32'hCAFE_F00D, 1'b1}) begin
      bad++; $display("FAIL wrap_ifid: got pc=%h ins=%h v=%b want 0/cafef00d/1", pc_out, instruction_out, valid_out);
    end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_misalign();
    drive(1'b0, 1'b1, 32'h42, 1'b0, 1'b0, 32'h0);
    step();
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL mis_addr: got %h want 40", imem_addr); end
    total++; if (misalign_err !== MisEn) begin bad++; $display("FAIL mis_flag: got %b want %b", misalign_err, MisEn); end
    drive(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    step();
    step();
    total++; if (misalign_err !== MisEn) begin bad++; $display("FAIL mis_sticky: got %b want %b", misalign_err, MisEn); end
    total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL mis_next_addr: got %h want 100", imem_addr); end
  endtask

  // Model view: a fetch stream with at most one accepted-but-unanswered request
  // (busy, possibly stale), an optional parked instruction, and the IF/ID contents.
  task automatic test_random();
    logic [31:0] m_pc, m_ppc, m_pins, e_pc, e_ins, ba, rd, tgt, rp_addr;
    logic        m_boot, m_busy, m_stale, m_park, e_val, e_mis, rp_pend;
    logic        fz, br, g, rv, exp_req, hs, took, good, deliver, hs_dut;
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_pc = 32'h0; m_boot = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_park = 1'b0;
    m_ppc = 32'h0; m_pins = 32'h0; e_pc = 32'h0; e_ins = 32'h0; e_val = 1'b0; e_mis = 1'b0;
    rp_pend = 1'b0; rp_addr = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(199) == 0) begin
        rst = 1'b0;
        #1;
        total++; if ({imem_req, valid_out, pc_out, instruction_out, misalign_err} !== 67'h0) begin
          bad++; $display("FAIL rnd_reset: got req=%b v=%b pc=%h ins=%h mis=%b want all 0",
                          imem_req, valid_out, pc_out, instruction_out, misalign_err);
        end
        m_pc = 32'h0; m_boot = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_park = 1'b0;
        e_pc = 32'h0; e_ins = 32'h0; e_val = 1'b0; e_mis = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        continue;
      end
      fz = ($urandom_range(3) == 0);
      br = ($urandom_range(11) == 0);
      case ($urandom_range(3))
        0:       ba = 32'hFFFF_FFFC;
        1:       ba = $urandom;
        default: ba = 32'($urandom_range(255)) << 2;
      endcase
      g  = ($urandom_range(9) < 6);
      rv = rp_pend && ($urandom_range(1) == 0);
      rd = mem_word(rp_addr);
      drive(fz, br, ba, g, rv, rd);
      #1;
      exp_req = !m_boot && !m_busy && !m_park && (!br || g);
      total++; if (imem_req !== exp_req) begin
        bad++; $display("FAIL rnd_req: cycle %0d got %b want %b", c, imem_req, exp_req);
      end
      if (exp_req) begin
        total++; if (imem_addr !== m_pc) begin
          bad++; $display("FAIL rnd_addr: cycle %0d got %h want %h", c, imem_addr, m_pc);
        end
      end
      // Memory side reacts to what the DUT actually presented.
      hs_dut = imem_req && g;
      if (rv) rp_pend = 1'b0;
      if (hs_dut) begin
        rp_pend = 1'b1;
        rp_addr = imem_addr;
      end
      tgt     = {ba[31:2], 2'b00};
      took    = m_busy && rv;
      good    = took && !m_stale;
      hs      = exp_req && g;
      deliver = !br && !fz && (m_park || good);
      if (br) begin
        e_pc = 32'h0; e_ins = 32'h0; e_val = 1'b0;
      end else if (!fz) begin
        if (m_park) begin
          e_pc = m_ppc; e_ins = m_pins; e_val = 1'b1;
        end else if (good) begin
          e_pc = m_pc + 32'd4; e_ins = rd; e_val = 1'b1;
        end else begin
          e_pc = 32'h0; e_ins = 32'h0; e_val = 1'b0;
        end
      end
      if (!br && fz && good) begin
        m_park = 1'b1; m_ppc = m_pc + 32'd4; m_pins = rd;
      end else if (br || !fz) begin
        m_park = 1'b0;
      end
      if (br) m_pc = tgt;
      else if (deliver) m_pc = m_pc + 32'd4;
      if (hs) begin
        m_busy = 1'b1; m_stale = br;
      end else if (took) begin
        m_busy = 1'b0; m_stale = 1'b0;
      end else if (m_busy && br) begin
        m_stale = 1'b1;
      end
      m_boot = 1'b0;
      if (MisEn && br && (ba[1:0] != 2'b00)) e_mis = 1'b1;
      step();
      total++; if ({pc_out, instruction_out, valid_out, misalign_err} !== {e_pc, e_ins, e_val, e_mis}) begin
        bad++; $display("FAIL rnd_ifid: cycle %0d got pc=%h ins=%h v=%b mis=%b want pc=%h ins=%h v=%b mis=%b",
                        c, pc_out, instruction_out, valid_out, misalign_err, e_pc, e_ins, e_val, e_mis);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_basic();
    test_freeze();
    test_branch_wait();
    test_branch_freeze();
    test_wrap();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port freeze, input, 1, hazard stall from ID; holds PC and IF/ID register.
REQ-005 SHALL have port branch_taken, input, 1, one-cycle redirect pulse from EX.
REQ-006 SHALL have port branch_addr, input, 32, redirect target.
REQ-007 SHALL have port imem_req, output, 1, instruction-memory request.
REQ-008 SHALL have port imem_addr, output, 32, request address (current PC).
REQ-009 SHALL have port imem_gnt, input, 1, request accepted this cycle.
REQ-010 SHALL have port imem_rvalid, input, 1, read data valid.
REQ-011 SHALL have port imem_rdata, input, 32, instruction word.
REQ-012 SHALL have ports pc_out (output, 32) and instruction_out (output, 32), registered IF/ID outputs to decode.
REQ-013 SHALL have port valid_out, output, 1, instruction_out holds a real instruction.
REQ-014 SHALL have port misalign_err, output, 1, sticky misaligned-target flag.

Function
REQ-015 SHALL keep at most one imem request outstanding.
REQ-016 SHALL implement FSM with states IDLE, REQ, WAIT, HOLD; IDLE lasts one cycle after reset, then moves to REQ.
REQ-017 In REQ, SHALL drive imem_req=1 and imem_addr=PC; on imem_gnt, SHALL move to WAIT.
REQ-018 In WAIT, on imem_rvalid with freeze=0, SHALL load pc_out=PC+4, instruction_out=imem_rdata, valid_out=1, set PC=PC+4, and return to REQ.
REQ-019 In WAIT, on imem_rvalid with freeze=1, SHALL capture rdata and PC+4 in a hold register and move to HOLD; PC is unchanged.
REQ-020 In HOLD, on freeze=0, SHALL load IF/ID from the hold register, set PC=PC+4, and move to REQ.
REQ-021 While freeze=1, SHALL leave pc_out, instruction_out and valid_out unchanged.
REQ-022 In any cycle with no instruction loaded and freeze=0, SHALL load a bubble: pc_out=0, instruction_out=0, valid_out=0.
REQ-023 On branch_taken, SHALL set PC=branch_addr, flush IF/ID to a bubble, discard any hold entry, and take priority over freeze.
REQ-024 On branch_taken in WAIT, or coincident with imem_gnt in REQ, SHALL set a kill flag, discard the next imem_rvalid, then move to REQ.
REQ-025 On branch_taken in REQ without imem_gnt, SHALL deassert imem_req for that cycle and re-request branch_addr next cycle.
REQ-026 SHALL wrap PC+4 modulo 2^32 (32'hFFFF_FFFC+4=0).
REQ-027 SHALL ignore imem_rvalid in IDLE, REQ and HOLD.

Reset
REQ-028 On rst=0, SHALL asynchronously set PC=RESET_PC, state=IDLE, kill=0, hold empty, pc_out=0, instruction_out=0, valid_out=0, misalign_err=0, imem_req=0.
REQ-029 After reset mid-transaction, SHALL discard any late imem_rvalid until its own request is granted.

Configuration
REQ-030 With IF_MISALIGN_CHECK_EN defined, a branch_taken with branch_addr[1:0]!=0 SHALL set misalign_err (sticky until reset) and force PC[1:0]=0.
REQ-031 Without IF_MISALIGN_CHECK_EN, SHALL take branch_addr[1:0] as 0 and tie misalign_err to 0.

Structure
REQ-032 The shared package arm_pkg SHALL hold the FSM state enum, WORD_LENGTH=32 and the bubble constant NOP_INSTR=32'h0.
REQ-033 The IF/ID output register SHALL be one sub-module, if_id_register, with load, flush and async active-low reset.

Verification
REQ-034 Reset release with imem_gnt=1 and rvalid one cycle after gnt, rdata=32'hE3A0_1005 -> imem_addr=0, then pc_out=4, instruction_out=32'hE3A0_1005, valid_out=1.
REQ-035 freeze=1 held 3 cycles while rvalid arrives with rdata=32'hE081_2002 -> IF/ID unchanged; after freeze=0 -> IF/ID loads it, next imem_addr=PC+4.
REQ-036 branch_taken with branch_addr=32'h40 while in WAIT -> IF/ID bubble, returning rdata discarded, next imem_addr=32'h40.
REQ-037 branch_taken with freeze=1 in the same cycle -> PC=branch_addr, IF/ID flushed (branch wins).
REQ-038 PC=32'hFFFF_FFFC fetch -> pc_out=0, next imem_addr=0.
REQ-039 With IF_MISALIGN_CHECK_EN, branch_addr=32'h42 -> misalign_err=1 and stays 1; imem_addr=32'h40.
